// File: rtl/periph_bus_arbiter_if.sv
// periph_bus_arbiter_if: request/response bundle between one bus master and the
// peripheral bus arbiter. The master drives the request and the arbiter returns
// the completion pulse, read data and error flag.
interface periph_bus_arbiter_if #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int STORE_W = 2
);
    logic               valid;
    logic [ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]  wdata;
    logic [STORE_W-1:0] store_type;
    logic [DATA_W-1:0]  rdata;
    logic               ready;
    logic               err;

    // Requesting side: core data port, DMA engine or debug port.
    modport master (
        output valid,
        output addr,
        output wdata,
        output store_type,
        input  rdata,
        input  ready,
        input  err
    );

    // Arbiter side: accepts the request and returns the completion.
    modport slave (
        input  valid,
        input  addr,
        input  wdata,
        input  store_type,
        output rdata,
        output ready,
        output err
    );
endinterface

// File: rtl/periph_bus_arbiter.sv
// periph_bus_arbiter: two-master round-robin arbiter and sequencer for the shared
// peripheral data bus (timer, VGA, stdout). One access is in flight at a time:
// IDLE grants, REQ/WAIT hold a registered slave request until s_ack, RESP returns
// a one-cycle ready pulse to the granted master.
// Optional feature macro: PERIPH_ARB_TIMEOUT_EN. When defined, a WAIT that sees
// no s_ack within TIMEOUT cycles completes with err = 1 and rdata = 0. When
// undefined, WAIT only exits on s_ack and both err outputs are tied low.
module periph_bus_arbiter #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int STORE_W = 2,
    parameter int TIMEOUT = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,

    periph_bus_arbiter_if.slave  m0,
    periph_bus_arbiter_if.slave  m1,

    output logic                 s_valid,
    output logic [ADDR_W-1:0]    s_addr,
    output logic [DATA_W-1:0]    s_wdata,
    output logic [STORE_W-1:0]   s_store_type,
    input  logic [DATA_W-1:0]    s_rdata,
    input  logic                 s_ack,

    output logic                 busy
);

    // The timeout counter is eight bits wide, so the setting must fit 2..255.
    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
        $error("periph_bus_arbiter: TIMEOUT must be in 2..255");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t             state_q,        state_d;
    logic               last_grant_q,   last_grant_d;
    logic               grant_q,        grant_d;
    logic               s_valid_q,      s_valid_d;
    logic [ADDR_W-1:0]  s_addr_q,       s_addr_d;
    logic [DATA_W-1:0]  s_wdata_q,      s_wdata_d;
    logic [STORE_W-1:0] s_store_type_q, s_store_type_d;
    logic               ack_seen_q,     ack_seen_d;
    logic [DATA_W-1:0]  cap_data_q,     cap_data_d;
    logic               m0_ready_q,     m0_ready_d;
    logic               m1_ready_q,     m1_ready_d;
    logic [DATA_W-1:0]  m0_rdata_q,     m0_rdata_d;
    logic [DATA_W-1:0]  m1_rdata_q,     m1_rdata_d;

    logic               new_grant;
    logic               resp_fire;
    logic [DATA_W-1:0]  resp_data;

`ifdef PERIPH_ARB_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    logic [7:0]         cnt_q,          cnt_d;
    logic               m0_err_q,       m0_err_d;
    logic               m1_err_q,       m1_err_d;
    logic               resp_err;
`endif

    // Round-robin choice: a lone requester wins, a tie goes to the master not served last.
    always_comb begin
        new_grant = 1'b0;
        if (m0.valid && m1.valid) begin
            new_grant = ~last_grant_q;
        end else begin
            new_grant = m1.valid;
        end
    end

    // Next-state, request capture and response generation for the access sequencer.
    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        grant_d        = grant_q;
        s_valid_d      = s_valid_q;
        s_addr_d       = s_addr_q;
        s_wdata_d      = s_wdata_q;
        s_store_type_d = s_store_type_q;
        ack_seen_d     = ack_seen_q;
        cap_data_d     = cap_data_q;
        m0_ready_d     = 1'b0;
        m1_ready_d     = 1'b0;
        m0_rdata_d     = m0_rdata_q;
        m1_rdata_d     = m1_rdata_q;
        resp_fire      = 1'b0;
        resp_data      = cap_data_q;
`ifdef PERIPH_ARB_TIMEOUT_EN
        cnt_d          = cnt_q;
        m0_err_d       = m0_err_q;
        m1_err_d       = m1_err_q;
        resp_err       = 1'b0;
`endif

        unique case (state_q)
            IDLE: begin
                if (m0.valid || m1.valid) begin
                    grant_d        = new_grant;
                    last_grant_d   = new_grant;
                    s_valid_d      = 1'b1;
                    s_addr_d       = new_grant ? m1.addr       : m0.addr;
                    s_wdata_d      = new_grant ? m1.wdata      : m0.wdata;
                    s_store_type_d = new_grant ? m1.store_type : m0.store_type;
                    ack_seen_d     = 1'b0;
                    state_d        = REQ;
                end
            end

            REQ: begin
                // An early ack is remembered so WAIT can finish on its first cycle.
                if (s_ack) begin
                    ack_seen_d = 1'b1;
                    cap_data_d = s_rdata;
                end
                state_d = WAIT;
            end

            WAIT: begin
`ifdef PERIPH_ARB_TIMEOUT_EN
                cnt_d = cnt_q + 8'd1;
`endif
                if (ack_seen_q || s_ack) begin
                    resp_fire = 1'b1;
                    resp_data = ack_seen_q ? cap_data_q : s_rdata;
`ifdef PERIPH_ARB_TIMEOUT_EN
                    resp_err  = 1'b0;
                end else if (cnt_q == TO_LAST) begin
                    resp_fire = 1'b1;
                    resp_data = '0;
                    resp_err  = 1'b1;
`endif
                end
            end

            RESP: begin
                ack_seen_d = 1'b0;
`ifdef PERIPH_ARB_TIMEOUT_EN
                cnt_d      = 8'd0;
`endif
                state_d    = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Completion: drop the slave request and present the result to the granted master only.
        if (resp_fire) begin
            state_d   = RESP;
            s_valid_d = 1'b0;
            if (grant_q) begin
                m1_ready_d = 1'b1;
                m1_rdata_d = resp_data;
`ifdef PERIPH_ARB_TIMEOUT_EN
                m1_err_d   = resp_err;
`endif
            end else begin
                m0_ready_d = 1'b1;
                m0_rdata_d = resp_data;
`ifdef PERIPH_ARB_TIMEOUT_EN
                m0_err_d   = resp_err;
`endif
            end
        end
    end

    // State and datapath registers; reset abandons any in-flight access and favours master 0.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            last_grant_q   <= 1'b1;
            grant_q        <= 1'b0;
            s_valid_q      <= 1'b0;
            s_addr_q       <= '0;
            s_wdata_q      <= '0;
            s_store_type_q <= '0;
            ack_seen_q     <= 1'b0;
            cap_data_q     <= '0;
            m0_ready_q     <= 1'b0;
            m1_ready_q     <= 1'b0;
            m0_rdata_q     <= '0;
            m1_rdata_q     <= '0;
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            grant_q        <= grant_d;
            s_valid_q      <= s_valid_d;
            s_addr_q       <= s_addr_d;
            s_wdata_q      <= s_wdata_d;
            s_store_type_q <= s_store_type_d;
            ack_seen_q     <= ack_seen_d;
            cap_data_q     <= cap_data_d;
            m0_ready_q     <= m0_ready_d;
            m1_ready_q     <= m1_ready_d;
            m0_rdata_q     <= m0_rdata_d;
            m1_rdata_q     <= m1_rdata_d;
        end
    end

`ifdef PERIPH_ARB_TIMEOUT_EN
    // Timeout counter and per-master error flags.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= 8'd0;
            m0_err_q <= 1'b0;
            m1_err_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            m0_err_q <= m0_err_d;
            m1_err_q <= m1_err_d;
        end
    end

    assign m0.err = m0_err_q;
    assign m1.err = m1_err_q;
`else
    assign m0.err = 1'b0;
    assign m1.err = 1'b0;
`endif

    assign m0.ready     = m0_ready_q;
    assign m0.rdata     = m0_rdata_q;
    assign m1.ready     = m1_ready_q;
    assign m1.rdata     = m1_rdata_q;

    assign s_valid      = s_valid_q;
    assign s_addr       = s_addr_q;
    assign s_wdata      = s_wdata_q;
    assign s_store_type = s_store_type_q;

    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// tb_periph_bus_arbiter: directed bench for periph_bus_arbiter. Inputs change and
// outputs are sampled 1 ns after each rising clock edge.
module tb_periph_bus_arbiter;

    localparam int ADDR_W  = 64;
    localparam int DATA_W  = 64;
    localparam int STORE_W = 2;
    localparam int TIMEOUT = 16;

    logic               clock = 1'b0;
    logic               reset_n = 1'b0;
    logic               s_valid;
    logic [ADDR_W-1:0]  s_addr;
    logic [DATA_W-1:0]  s_wdata;
    logic [STORE_W-1:0] s_store_type;
    logic [DATA_W-1:0]  s_rdata = '0;
    logic               s_ack = 1'b0;
    logic               busy;

    int n_cmp = 0;
    int n_err = 0;

    periph_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STORE_W(STORE_W)) m0_if ();
    periph_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STORE_W(STORE_W)) m1_if ();

    periph_bus_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .STORE_W (STORE_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .m0           (m0_if),
        .m1           (m1_if),
        .s_valid      (s_valid),
        .s_addr       (s_addr),
        .s_wdata      (s_wdata),
        .s_store_type (s_store_type),
        .s_rdata      (s_rdata),
        .s_ack        (s_ack),
        .busy         (busy)
    );

    // 100 MHz clock.
    always #5 clock = ~clock;

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input int m, input logic [63:0] addr,
                                  input logic [63:0] wdata, input logic [1:0] st);
        if (m == 0) begin
            m0_if.valid = 1'b1; m0_if.addr = addr; m0_if.wdata = wdata; m0_if.store_type = st;
        end else begin
            m1_if.valid = 1'b1; m1_if.addr = addr; m1_if.wdata = wdata; m1_if.store_type = st;
        end
    endtask

    initial begin
        m0_if.valid = 1'b0; m0_if.addr = '0; m0_if.wdata = '0; m0_if.store_type = '0;
        m1_if.valid = 1'b0; m1_if.addr = '0; m1_if.wdata = '0; m1_if.store_type = '0;

        // ---------------- reset state ----------------
        tick(); tick();
        check_output("rst_s_valid",  64'(s_valid),     64'd0);
        check_output("rst_busy",     64'(busy),        64'd0);
        check_output("rst_m0_ready", 64'(m0_if.ready), 64'd0);
        check_output("rst_m1_ready", 64'(m1_if.ready), 64'd0);
        check_output("rst_m0_rdata", m0_if.rdata,      64'd0);
        check_output("rst_m0_err",   64'(m0_if.err),   64'd0);
        check_output("rst_s_addr",   s_addr,           64'd0);
        reset_n = 1'b1;
        tick();

        // ---------------- single read on m0, ack two cycles after s_valid ----------------
        apply_stimulus(0, 64'h2000_0000, 64'h0, 2'd0);
        tick();                                   // grant edge n: REQ
        check_output("rd_s_valid_rise", 64'(s_valid), 64'd1);
        check_output("rd_busy",         64'(busy),    64'd1);
        check_output("rd_s_addr",       s_addr,       64'h2000_0000);
        check_output("rd_s_store",      64'(s_store_type), 64'd0);
        tick();                                   // WAIT
        tick();                                   // WAIT, two cycles after s_valid rose
        check_output("rd_s_valid_hold", 64'(s_valid), 64'd1);
        s_ack = 1'b1; s_rdata = 64'h1234;
        tick();                                   // RESP
        s_ack = 1'b0; s_rdata = '0;
        check_output("rd_m0_ready",  64'(m0_if.ready), 64'd1);
        check_output("rd_m0_rdata",  m0_if.rdata,      64'h1234);
        check_output("rd_m0_err",    64'(m0_if.err),   64'd0);
        check_output("rd_s_valid_0", 64'(s_valid),     64'd0);
        check_output("rd_m1_ready",  64'(m1_if.ready), 64'd0);
        m0_if.valid = 1'b0;
        tick();                                   // IDLE
        check_output("rd_ready_pulse", 64'(m0_if.ready), 64'd0);
        check_output("rd_idle_busy",   64'(busy),        64'd0);
        check_output("rd_rdata_hold",  m0_if.rdata,      64'h1234);

        // ---------------- write on m1, ack during REQ (minimum latency) ----------------
        apply_stimulus(1, 64'h3000, 64'hDEAD_BEEF, 2'd1);
        tick();                                   // REQ
        check_output("wr_s_valid", 64'(s_valid),      64'd1);
        check_output("wr_s_wdata", s_wdata,           64'hDEAD_BEEF);
        check_output("wr_s_store", 64'(s_store_type), 64'd1);
        check_output("wr_s_addr",  s_addr,            64'h3000);
        s_ack = 1'b1; s_rdata = 64'h55;
        tick();                                   // WAIT with early ack remembered
        s_ack = 1'b0;
        check_output("wr_s_valid_wait", 64'(s_valid), 64'd1);
        check_output("wr_no_early_rdy", 64'(m1_if.ready), 64'd0);
        tick();                                   // RESP at n+2 after grant edge
        check_output("wr_m1_ready",  64'(m1_if.ready), 64'd1);
        check_output("wr_m0_quiet",  64'(m0_if.ready), 64'd0);
        check_output("wr_m1_err",    64'(m1_if.err),   64'd0);
        check_output("wr_m0_rdata_kept", m0_if.rdata,  64'h1234);
        m1_if.valid = 1'b0;
        tick();                                   // IDLE

        // ---------------- contention: 4 back-to-back transactions ----------------
        apply_stimulus(0, 64'hA000, 64'h0, 2'd0);
        apply_stimulus(1, 64'hB000, 64'h0, 2'd0);
        for (int k = 0; k < 4; k++) begin
            tick();                               // grant
            check_output($sformatf("ct%0d_s_addr", k), s_addr,
                         (k % 2 == 0) ? 64'hA000 : 64'hB000);
            s_ack = 1'b1; s_rdata = 64'h100 + 64'(k);
            tick();                               // WAIT
            s_ack = 1'b0;
            tick();                               // RESP
            check_output($sformatf("ct%0d_m0_ready", k), 64'(m0_if.ready),
                         (k % 2 == 0) ? 64'd1 : 64'd0);
            check_output($sformatf("ct%0d_m1_ready", k), 64'(m1_if.ready),
                         (k % 2 == 0) ? 64'd0 : 64'd1);
            if (k % 2 == 0) check_output($sformatf("ct%0d_rdata", k), m0_if.rdata, 64'h100 + 64'(k));
            else            check_output($sformatf("ct%0d_rdata", k), m1_if.rdata, 64'h100 + 64'(k));
            tick();                               // mandatory idle cycle
            check_output($sformatf("ct%0d_idle", k), 64'(busy), 64'd0);
        end
        m0_if.valid = 1'b0;
        m1_if.valid = 1'b0;

        // ---------------- request stability: master changes after grant ----------------
        apply_stimulus(0, 64'h4000, 64'h0, 2'd0);
        tick();                                   // REQ
        m0_if.valid = 1'b0; m0_if.addr = 64'hFFFF;
        tick();                                   // WAIT
        check_output("st_s_addr", s_addr,     64'h4000);
        check_output("st_busy",   64'(busy),  64'd1);
        s_ack = 1'b1; s_rdata = 64'hABCD;
        tick();                                   // RESP
        s_ack = 1'b0;
        check_output("st_m0_ready", 64'(m0_if.ready), 64'd1);
        check_output("st_m0_rdata", m0_if.rdata,      64'hABCD);
        tick();                                   // IDLE

        // ---------------- stray ack in IDLE ----------------
        s_ack = 1'b1; s_rdata = 64'hEEEE;
        tick();
        s_ack = 1'b0;
        check_output("stray_busy",     64'(busy),        64'd0);
        check_output("stray_m0_ready", 64'(m0_if.ready), 64'd0);
        check_output("stray_m1_ready", 64'(m1_if.ready), 64'd0);
        check_output("stray_m0_rdata", m0_if.rdata,      64'hABCD);

`ifdef PERIPH_ARB_TIMEOUT_EN
        // ---------------- timeout: no ack, 16 WAIT cycles ----------------
        apply_stimulus(0, 64'h7000, 64'h0, 2'd0);
        tick();                                   // REQ
        tick();                                   // WAIT entered, counter 0
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        check_output("to_not_yet", 64'(m0_if.ready), 64'd0);
        check_output("to_busy",    64'(busy),        64'd1);
        tick();                                   // 16th WAIT cycle ends: RESP
        check_output("to_m0_ready", 64'(m0_if.ready), 64'd1);
        check_output("to_m0_err",   64'(m0_if.err),   64'd1);
        check_output("to_m0_rdata", m0_if.rdata,      64'd0);
        m0_if.valid = 1'b0;
        tick();

        // ---------------- ack and timeout on the same cycle ----------------
        apply_stimulus(0, 64'h7100, 64'h0, 2'd0);
        tick();                                   // REQ
        tick();                                   // WAIT, counter 0
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        s_ack = 1'b1; s_rdata = 64'h9999;         // counter = TIMEOUT-1
        tick();
        s_ack = 1'b0;
        check_output("col_m0_ready", 64'(m0_if.ready), 64'd1);
        check_output("col_m0_err",   64'(m0_if.err),   64'd0);
        check_output("col_m0_rdata", m0_if.rdata,      64'h9999);
        m0_if.valid = 1'b0;
        tick();
`else
        // ---------------- no timeout: WAIT holds until ack at cycle 40 ----------------
        apply_stimulus(0, 64'h7000, 64'h0, 2'd0);
        tick();                                   // REQ
        for (int i = 0; i < 39; i++) tick();
        check_output("nto_busy",  64'(busy),        64'd1);
        check_output("nto_ready", 64'(m0_if.ready), 64'd0);
        check_output("nto_s_valid", 64'(s_valid),   64'd1);
        s_ack = 1'b1; s_rdata = 64'h77;
        tick();
        s_ack = 1'b0;
        check_output("nto_m0_ready", 64'(m0_if.ready), 64'd1);
        check_output("nto_m0_err",   64'(m0_if.err),   64'd0);
        check_output("nto_m0_rdata", m0_if.rdata,      64'h77);
        m0_if.valid = 1'b0;
        tick();
`endif

        // ---------------- asynchronous reset during WAIT ----------------
        apply_stimulus(1, 64'h5000, 64'h0, 2'd0);
        tick();                                   // REQ
        tick();                                   // WAIT
        check_output("ar_busy_pre",    64'(busy),    64'd1);
        check_output("ar_s_valid_pre", 64'(s_valid), 64'd1);
        reset_n = 1'b0;
        #1;                                       // well before the next clock edge
        check_output("ar_s_valid", 64'(s_valid),     64'd0);
        check_output("ar_busy",    64'(busy),        64'd0);
        check_output("ar_m0_ready", 64'(m0_if.ready), 64'd0);
        check_output("ar_m1_ready", 64'(m1_if.ready), 64'd0);
        check_output("ar_m1_rdata", m1_if.rdata,      64'd0);
        apply_stimulus(0, 64'h6000, 64'h0, 2'd0);
        tick();
        check_output("ar_no_ready_in_rst", 64'(m1_if.ready), 64'd0);
        reset_n = 1'b1;
        tick();                                   // both request, master 0 wins after reset
        check_output("ar_first_grant", s_addr, 64'h6000);
        s_ack = 1'b1; s_rdata = 64'h6666;
        tick();
        s_ack = 1'b0;
        tick();                                   // RESP
        check_output("ar_m0_ready", 64'(m0_if.ready), 64'd1);
        check_output("ar_m1_idle",  64'(m1_if.ready), 64'd0);
        m0_if.valid = 1'b0;
        m1_if.valid = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
